sdram_burst_arbiter: RTL and testbench
======================================

# sdram_burst_arbiter

Two-client burst arbiter that shares the single write-FIFO / read-FIFO host port of the SDRAM frame-buffer controller between two requesters, e.g. the RW test engine and a second streaming master. It sits in the test-clock domain between the clients and the controller. It grants whole fixed-length bursts round-robin, and for each burst it drives the address load, settle delay, word streaming with FIFO flow control, and completion signalling.

## Interface
- AW, 24, address width (matches controller WR_ADDR/RD_ADDR)
- DW, 16, data width
- BURST_LEN, 128, words per burst (matches controller WR_LENGTH/RD_LENGTH); range 1..511
- SETTLE, 4, idle cycles between address load pulse and first word; range 1..15
- iCLK  in  1  test clock; all logic on rising edge
- iRST  in  1  asynchronous, active-high reset
- c0_req, c1_req  in  1  burst request; hold high until the client's done pulse
- c0_we, c1_we  in  1  1 = write burst, 0 = read burst; sampled at grant
- c0_addr, c1_addr  in  AW  burst start address; sampled at grant
- c0_wdata, c1_wdata  in  DW  current write word; advance on own ack
- c0_ack, c1_ack  out  1  write word accepted this cycle
- c0_rvalid, c1_rvalid  out  1  read word valid on rdata
- rdata  out  DW  read data, shared by both clients (= iRD_DATA)
- c0_done, c1_done  out  1  one-cycle burst-complete pulse
- oWR, oWR_DATA[DW], oWR_ADDR[AW], oWR_LOAD  out  write FIFO side of controller
- iWR_FULL  in  1  write FIFO full
- oRD, oRD_ADDR[AW], oRD_LOAD  out  read FIFO side of controller
- iRD_DATA  in  DW  read FIFO data, valid the cycle after oRD
- iRD_EMPTY  in  1  read FIFO empty
- oGRANT  out  2  one-hot granted client, 00 = none
- oBUSY  out  1  state != IDLE

## Operation
- States: IDLE -> LOAD -> SETTLE -> XFER -> DRAIN (read only) -> DONE -> IDLE.
- IDLE:
  - If any req is high, choose a client. If only one requests, it wins. If both request, the client not served last wins.
  - Latch the winner's we and addr, and set oGRANT. Go to LOAD.
- LOAD, 1 cycle:
  - Write burst: oWR_LOAD=1. Read burst: oRD_LOAD=1.
  - The matching oWR_ADDR or oRD_ADDR holds the latched addr from this cycle until the next grant.
- SETTLE: count SETTLE cycles with no transfers, then go to XFER with word counter = 0.
- XFER, write:
  - oWR = !iWR_FULL. oWR_DATA = granted wdata. The granted client's ack equals oWR.
  - The counter increments on each oWR. After word BURST_LEN-1 is accepted, go to DONE.
- XFER, read:
  - oRD = !iRD_EMPTY, and the counter increments on each oRD.
  - Granted rvalid = oRD delayed one cycle through a register.
  - After the last oRD, go to DRAIN.
- DRAIN, 1 cycle: the last rvalid is presented. Go to DONE.
- DONE, 1 cycle:
  - Pulse done to the granted client.
  - Record the last-served client, clear oGRANT, go to IDLE.
- Non-granted clients see ack=0, rvalid=0 and done=0 at all times.
- A client dropping req mid-burst is ignored; the burst runs to completion.
- Reset, including mid-burst:
  - State = IDLE; all outputs 0; counters 0.
  - Last-served = client 1, so client 0 wins the first tie.
  - The burst in progress is abandoned. No done pulse is issued.
- Counter width is ceil(log2(BURST_LEN+1)). There is no address arithmetic; the controller increments addresses internally.

## Timing
- req high at edge N with state IDLE: LOAD during cycle N+1 (load pulse), SETTLE cycles N+2..N+1+SETTLE, first possible word at N+2+SETTLE.
- Unstalled write burst: the done pulse comes BURST_LEN+SETTLE+3 cycles after the grant edge.
- Unstalled read burst: one extra cycle for DRAIN.
- Back-to-back: after DONE, IDLE takes one cycle. The minimum gap between bursts is 1 idle cycle plus load and settle.
- Stalls: iWR_FULL or iRD_EMPTY high holds the counter. Unlimited stall length is allowed. No words are lost or duplicated.
- ack, oWR and oRD are combinational from state and the FIFO flags. rvalid, done and oGRANT are registered.

## Test plan
- Single write, c0, addr=0x000100, BURST_LEN=8, SETTLE=4, no full -> oWR_LOAD pulse with oWR_ADDR=0x000100; exactly 8 acks on consecutive cycles 6..13 after req; c0_done one cycle; c1 outputs stay 0.
- Single read, c1, BURST_LEN=8, iRD_DATA=0xA5A0+k -> 8 oRD strobes; 8 c1_rvalid pulses, each one cycle after its oRD, carrying 0xA5A0..0xA5A7; c1_done after DRAIN.
- Both req held continuously -> grants alternate c0, c1, c0, c1; after reset, first grant is c0.
- Write burst with iWR_FULL toggled randomly 50% -> exactly BURST_LEN oWR strobes; oWR_DATA sequence equals the client's word sequence with no gaps or repeats.
- iRST asserted during XFER after 3 of 8 words -> all outputs 0 immediately; no done; the next request restarts with a fresh LOAD.
- c0 drops req after word 2 -> burst still completes 8 words and c0_done pulses.

Source files
------------

// File: rtl/sdram_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_burst_arbiter
//  Brief    : Two-client round-robin burst arbiter in front of the SDRAM
//             frame-buffer controller write/read FIFO host port. Grants whole
//             fixed-length bursts and sequences load, settle, streaming and
//             completion for each one.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_burst_arbiter #(
    parameter int AW        = 24,
    parameter int DW        = 16,
    parameter int BURST_LEN = 128,
    parameter int SETTLE    = 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    // client 0
    input  logic          c0_req,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_ack,
    output logic          c0_rvalid,
    output logic          c0_done,
    // client 1
    input  logic          c1_req,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_ack,
    output logic          c1_rvalid,
    output logic          c1_done,
    // shared read data
    output logic [DW-1:0] rdata,
    // controller write FIFO side
    output logic          oWR,
    output logic [DW-1:0] oWR_DATA,
    output logic [AW-1:0] oWR_ADDR,
    output logic          oWR_LOAD,
    input  logic          iWR_FULL,
    // controller read FIFO side
    output logic          oRD,
    output logic [AW-1:0] oRD_ADDR,
    output logic          oRD_LOAD,
    input  logic [DW-1:0] iRD_DATA,
    input  logic          iRD_EMPTY,
    // status
    output logic [1:0]    oGRANT,
    output logic          oBUSY
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int SW = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_XFER   = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t         state_q;
    logic [1:0]     grant_q;
    logic           we_q;
    logic           last_q;        // last client served: 0 = c0, 1 = c1
    logic [CW-1:0]  cnt_q;
    logic [SW-1:0]  settle_q;
    logic           wr_load_q;
    logic           rd_load_q;
    logic [AW-1:0]  wr_addr_q;
    logic [AW-1:0]  rd_addr_q;
    logic           c0_rvalid_q;
    logic           c1_rvalid_q;
    logic           c0_done_q;
    logic           c1_done_q;

    logic           w_pick_c1;
    logic           w_xfer_wr;
    logic           w_wr_fire;
    logic           w_rd_fire;
    logic           w_last;

    // Arbitration: a lone requester wins; on a tie the client not served last wins.
    assign w_pick_c1 = c1_req && (!c0_req || !last_q);

    // Word strobes are combinational so FIFO flags throttle in the same cycle.
    assign w_xfer_wr = (state_q == S_XFER) && we_q;
    assign w_wr_fire = w_xfer_wr && !iWR_FULL;
    assign w_rd_fire = (state_q == S_XFER) && !we_q && !iRD_EMPTY;
    assign w_last    = (cnt_q == CW'(BURST_LEN - 1));

    assign oWR       = w_wr_fire;
    assign oRD       = w_rd_fire;
    assign c0_ack    = w_wr_fire && grant_q[0];
    assign c1_ack    = w_wr_fire && grant_q[1];
    assign oWR_DATA  = w_xfer_wr ? (grant_q[1] ? c1_wdata : c0_wdata) : '0;
    assign oWR_ADDR  = wr_addr_q;
    assign oRD_ADDR  = rd_addr_q;
    assign oWR_LOAD  = wr_load_q;
    assign oRD_LOAD  = rd_load_q;
    assign c0_rvalid = c0_rvalid_q;
    assign c1_rvalid = c1_rvalid_q;
    assign c0_done   = c0_done_q;
    assign c1_done   = c1_done_q;
    assign rdata     = iRD_DATA;
    assign oGRANT    = grant_q;
    assign oBUSY     = (state_q != S_IDLE);

    // Burst sequencer with registered grant, load, rvalid and done outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            we_q        <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            settle_q    <= '0;
            wr_load_q   <= 1'b0;
            rd_load_q   <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            c0_rvalid_q <= 1'b0;
            c1_rvalid_q <= 1'b0;
            c0_done_q   <= 1'b0;
            c1_done_q   <= 1'b0;
        end else begin
            // Read data from the FIFO appears one cycle after the pop.
            c0_rvalid_q <= w_rd_fire && grant_q[0];
            c1_rvalid_q <= w_rd_fire && grant_q[1];
            c0_done_q   <= 1'b0;
            c1_done_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (c0_req || c1_req) begin
                        grant_q <= w_pick_c1 ? 2'b10 : 2'b01;
                        we_q    <= w_pick_c1 ? c1_we : c0_we;
                        if (w_pick_c1 ? c1_we : c0_we) begin
                            wr_addr_q <= w_pick_c1 ? c1_addr : c0_addr;
                            wr_load_q <= 1'b1;
                        end else begin
                            rd_addr_q <= w_pick_c1 ? c1_addr : c0_addr;
                            rd_load_q <= 1'b1;
                        end
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wr_load_q <= 1'b0;
                    rd_load_q <= 1'b0;
                    settle_q  <= '0;
                    state_q   <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == SW'(SETTLE - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_XFER;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                S_XFER: begin
                    if (w_wr_fire || w_rd_fire) begin
                        if (w_last) begin
                            cnt_q   <= '0;
                            state_q <= we_q ? S_DONE : S_DRAIN;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    c0_done_q <= grant_q[0];
                    c1_done_q <= grant_q[1];
                    last_q    <= grant_q[1];
                    grant_q   <= 2'b00;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_burst_arbiter
//  Brief    : Self-checking bench for sdram_burst_arbiter. A cycle-indexed
//             reference model derives every expected output from the burst
//             timing rules (grant edge, load, settle window, word count).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_burst_arbiter;

    localparam int AW    = 24;
    localparam int DW    = 16;
    localparam int BL    = 8;
    localparam int ST    = 4;
    localparam int LIMIT = 400;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          c0_req, c1_req, c0_we, c1_we;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic          c0_ack, c1_ack, c0_rvalid, c1_rvalid, c0_done, c1_done;
    logic [DW-1:0] rdata;
    logic          oWR, oWR_LOAD, iWR_FULL;
    logic [DW-1:0] oWR_DATA;
    logic [AW-1:0] oWR_ADDR, oRD_ADDR;
    logic          oRD, oRD_LOAD, iRD_EMPTY;
    logic [DW-1:0] iRD_DATA;
    logic [1:0]    oGRANT;
    logic          oBUSY;

    int checks = 0;
    int errors = 0;
    bit last_served;   // model: 0 = c0 served last, 1 = c1

    always #5 iCLK = ~iCLK;

    sdram_burst_arbiter #(
        .AW(AW), .DW(DW), .BURST_LEN(BL), .SETTLE(ST)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_ack(c0_ack), .c0_rvalid(c0_rvalid), .c0_done(c0_done),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_ack(c1_ack), .c1_rvalid(c1_rvalid), .c1_done(c1_done),
        .rdata(rdata),
        .oWR(oWR), .oWR_DATA(oWR_DATA), .oWR_ADDR(oWR_ADDR), .oWR_LOAD(oWR_LOAD),
        .iWR_FULL(iWR_FULL),
        .oRD(oRD), .oRD_ADDR(oRD_ADDR), .oRD_LOAD(oRD_LOAD),
        .iRD_DATA(iRD_DATA), .iRD_EMPTY(iRD_EMPTY),
        .oGRANT(oGRANT), .oBUSY(oBUSY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({c0_ack, c1_ack, c0_rvalid, c1_rvalid, c0_done, c1_done,
                                  oWR, oWR_LOAD, oRD, oRD_LOAD, oGRANT, oBUSY}), 32'd0);
        check({tag, "_wr_addr"}, 32'(oWR_ADDR), 32'd0);
        check({tag, "_rd_addr"}, 32'(oRD_ADDR), 32'd0);
        check({tag, "_wr_data"}, 32'(oWR_DATA), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge iCLK);
        iRST = 1'b1; c0_req = 1'b0; c1_req = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge iCLK);
        #1;
        check_all_zero("reset_hold");
        iRST = 1'b0;
        last_served = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge iCLK);
        #1;
        check("idle_grant", 32'(oGRANT), 32'd0);
        check("idle_busy", 32'(oBUSY), 32'd0);
    endtask

    // Runs one burst; the caller has already set req/we/addr in the current
    // (idle) cycle, so iteration t=1 is the cycle after the grant edge.
    task automatic run_burst(input bit keep_req, input bit stall,
                             input int drop_after, input int abort_after);
        bit            win, we, fin, full, empty, xfer, e_wr, e_rd, e_rv, e_done, prev_rd;
        int            t, w, done_t;
        logic [AW-1:0] addr;
        logic [DW-1:0] wbase, rbase, word, prev_word;
        logic [1:0]    onehot;
        win    = (c0_req && c1_req) ? !last_served : c1_req;
        we     = win ? c1_we : c0_we;
        addr   = win ? c1_addr : c0_addr;
        onehot = win ? 2'b10 : 2'b01;
        wbase  = DW'($urandom);
        rbase  = 16'hA5A0;
        t = 1; w = 0; done_t = -1; fin = 1'b0; prev_rd = 1'b0; prev_word = '0;
        while (!fin && t <= LIMIT) begin
            @(negedge iCLK);
            full      = stall && ($urandom_range(0, 1) == 1);
            empty     = stall && ($urandom_range(0, 1) == 1);
            iWR_FULL  = full;
            iRD_EMPTY = empty;
            word      = wbase + DW'(w);
            if (win) begin c1_wdata = word; c0_wdata = ~word; end
            else     begin c0_wdata = word; c1_wdata = ~word; end
            iRD_DATA  = prev_rd ? prev_word : DW'($urandom);
            e_done    = (done_t == t);
            if ((drop_after >= 0 && w >= drop_after) || (e_done && !keep_req)) begin
                if (win) c1_req = 1'b0; else c0_req = 1'b0;
            end
            #1;
            xfer = (t >= ST + 2) && (w < BL);
            e_wr = xfer && we && !full;
            e_rd = xfer && !we && !empty;
            e_rv = prev_rd;
            check("grant", 32'(oGRANT), e_done ? 32'd0 : 32'(onehot));
            check("busy", 32'(oBUSY), 32'(!e_done));
            check("wr_load", 32'(oWR_LOAD), 32'(t == 1 && we));
            check("rd_load", 32'(oRD_LOAD), 32'(t == 1 && !we));
            if (we) check("wr_addr", 32'(oWR_ADDR), 32'(addr));
            else    check("rd_addr", 32'(oRD_ADDR), 32'(addr));
            check("oWR", 32'(oWR), 32'(e_wr));
            check("oRD", 32'(oRD), 32'(e_rd));
            check("c0_ack", 32'(c0_ack), 32'(e_wr && !win));
            check("c1_ack", 32'(c1_ack), 32'(e_wr && win));
            if (e_wr) check("wr_data", 32'(oWR_DATA), 32'(wbase + DW'(w)));
            check("c0_rvalid", 32'(c0_rvalid), 32'(e_rv && !win));
            check("c1_rvalid", 32'(c1_rvalid), 32'(e_rv && win));
            if (e_rv) check("rdata", 32'(rdata), 32'(rbase + DW'(w - 1)));
            check("c0_done", 32'(c0_done), 32'(e_done && !win));
            check("c1_done", 32'(c1_done), 32'(e_done && win));
            prev_rd = e_rd;
            if (e_wr || e_rd) begin
                prev_word = rbase + DW'(w);
                if (w == BL - 1) done_t = t + (we ? 2 : 3);
                w++;
            end
            if (e_done) begin
                last_served = win;
                fin = 1'b1;
            end
            t++;
            if (!fin && abort_after >= 0 && w == abort_after) begin
                @(negedge iCLK);
                iRST = 1'b1; c0_req = 1'b0; c1_req = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge iCLK);
                #1;
                check_all_zero("abort_hold");
                iRST = 1'b0;
                last_served = 1'b1;
                fin = 1'b1;
            end
        end
        check("burst_finished", 32'(fin), 32'd1);
    endtask

    initial begin
        iRST = 1'b1;
        c0_req = 1'b0; c1_req = 1'b0; c0_we = 1'b0; c1_we = 1'b0;
        c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
        iWR_FULL = 1'b0; iRD_EMPTY = 1'b0; iRD_DATA = '0;
        last_served = 1'b1;
        apply_reset();
        idle_cycle();

        // single unstalled write from c0
        c0_we = 1'b1; c0_addr = 24'h000100; c0_req = 1'b1;
        run_burst(1'b0, 1'b0, -1, -1);
        idle_cycle();

        // single unstalled read from c1
        c1_we = 1'b0; c1_addr = AW'($urandom); c1_req = 1'b1;
        run_burst(1'b0, 1'b0, -1, -1);
        idle_cycle();

        // both requesting continuously: alternation starting at c0 after reset
        apply_reset();
        c0_we = 1'b1; c1_we = 1'b0;
        c0_addr = AW'($urandom); c1_addr = AW'($urandom);
        c0_req = 1'b1; c1_req = 1'b1;
        for (int i = 0; i < 4; i++) run_burst(1'b1, 1'b0, -1, -1);
        apply_reset();

        // stalled writes and reads
        for (int i = 0; i < 3; i++) begin
            c0_we = 1'b1; c0_addr = AW'($urandom); c0_req = 1'b1;
            run_burst(1'b0, 1'b1, -1, -1);
            c1_we = 1'b0; c1_addr = AW'($urandom); c1_req = 1'b1;
            run_burst(1'b0, 1'b1, -1, -1);
        end
        idle_cycle();

        // reset after 3 of 8 words, then a fresh burst
        c0_we = 1'b1; c0_addr = AW'($urandom); c0_req = 1'b1;
        run_burst(1'b0, 1'b0, -1, 3);
        idle_cycle();
        c0_we = 1'b1; c0_addr = AW'($urandom); c0_req = 1'b1;
        run_burst(1'b0, 1'b0, -1, -1);

        // client drops req after word 2; burst must still complete
        c0_we = 1'b1; c0_addr = AW'($urandom); c0_req = 1'b1;
        run_burst(1'b0, 1'b0, 2, -1);
        idle_cycle();

        // randomized single-client bursts with random stalls
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                c1_we = 1'($urandom_range(0, 1)); c1_addr = AW'($urandom); c1_req = 1'b1;
            end else begin
                c0_we = 1'($urandom_range(0, 1)); c0_addr = AW'($urandom); c0_req = 1'b1;
            end
            run_burst(1'b0, 1'b1, -1, -1);
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
